// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple (daisy-chain) adder built from one full-adder cell per bit.
module fulladder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  logic [32:0] c;

  assign c[0] = carry_i;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[32];

endmodule

// File: rtl/shift_add_mul32.sv
// Sequential 32x32 unsigned multiplier: one shift-and-add step per cycle through
// fulladder32, 32 busy cycles per product, valid/ready on both sides.
module shift_add_mul32
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [1:0]           state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and a_i/b_i are sampled only
  // on the accepting edge.

  if (WIDTH != 32) begin : g_width_check
    $error("shift_add_mul32: WIDTH must be 32 to match fulladder32");
  end

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;

  assign add_b = lo[0] ? mcand : '0;

  fulladder32 u_adder (
    .a_i     (hi),
    .b_i     (add_b),
    .carry_i (1'b0),
    .sum_o   (add_s),
    .carry_o (add_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            mcand <= a_i;
            hi    <= '0;
            lo    <= b_i;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Carry lands in hi[31] via the 65-bit right shift, so nothing is lost.
          {hi, lo} <= {add_c, add_s, lo[WIDTH-1:1]};
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o   = (state == IDLE);
  assign valid_o   = (state == DONE);
  assign product_o = {hi, lo};
  assign state_o   = state;

endmodule
